// File: rtl/box_clean_scheduler_pkg.sv
// Shared types for the box-clean scheduler: FSM state encoding and the queued job record.
package box_clean_scheduler_pkg;

    localparam int BOX_XSZ = 8;
    localparam int BOX_YSZ = 7;

    // state        | meaning
    // ST_IDLE      | no job in flight; launch when a job is queued and the engine reports done
    // ST_LAUNCH    | go_clean pulse to the engine, box outputs already loaded
    // ST_WAIT_LOW  | wait for the engine to leave its done state
    // ST_WAIT_DONE | wait for the engine to report done again
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

    // Stored job width is fixed here; the scheduler's XSZ/YSZ defaults follow it.
    typedef struct packed {
        logic [BOX_XSZ-1:0] x_left;
        logic [BOX_XSZ-1:0] x_right;
        logic [BOX_YSZ-1:0] y_top;
        logic [BOX_YSZ-1:0] y_bottom;
    } box_job_t;

    function automatic logic box_misordered(input box_job_t job);
        return (job.x_left > job.x_right) || (job.y_top > job.y_bottom);
    endfunction

endpackage

// File: rtl/box_clean_scheduler_if.sv
// Job request handshake plus clean-engine control signals of the box-clean scheduler.
interface box_clean_scheduler_if #(
    parameter int XSZ   = 8,
    parameter int YSZ   = 7,
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH + 1);

    logic           job_valid;
    logic           job_ready;
    logic [XSZ-1:0] job_x_left;
    logic [XSZ-1:0] job_x_right;
    logic [YSZ-1:0] job_y_top;
    logic [YSZ-1:0] job_y_bottom;
    logic [XSZ-1:0] x_left;
    logic [XSZ-1:0] x_right;
    logic [YSZ-1:0] y_top;
    logic [YSZ-1:0] y_bottom;
    logic           go_clean;
    logic           done_clean;
    logic           busy;
    logic [PW-1:0]  pending;
    logic           bad_box;

    modport master (
        output job_valid, job_x_left, job_x_right, job_y_top, job_y_bottom, done_clean,
        input  job_ready, x_left, x_right, y_top, y_bottom, go_clean, busy, pending, bad_box
    );

    modport slave (
        input  job_valid, job_x_left, job_x_right, job_y_top, job_y_bottom, done_clean,
        output job_ready, x_left, x_right, y_top, y_bottom, go_clean, busy, pending, bad_box
    );

endinterface

// File: rtl/box_job_fifo.sv
// Job FIFO for the box-clean scheduler; DEPTH must be a power of two so pointers wrap naturally.
module box_job_fifo
    import box_clean_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic                         pop,
    input  box_job_t                     din,
    output box_job_t                     dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    box_job_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/box_clean_scheduler.sv
// Queues box-clean jobs and launches them one at a time on the clean engine.
// Optional BOX_ORDER_CHECK_EN: drop jobs with inverted bounds and pulse bad_box.
module box_clean_scheduler
    import box_clean_scheduler_pkg::*;
#(
    parameter int XSZ   = BOX_XSZ,
    parameter int YSZ   = BOX_YSZ,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    box_clean_scheduler_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    sched_state_t    state;
    sched_state_t    state_nxt;
    box_job_t        job_in;
    box_job_t        head;
    logic            accept;
    logic            fifo_push;
    logic            fifo_pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            go_clean_c;
    logic            busy_c;
    logic [XSZ-1:0]  x_left_q;
    logic [XSZ-1:0]  x_right_q;
    logic [YSZ-1:0]  y_top_q;
    logic [YSZ-1:0]  y_bottom_q;

    assign job_in = '{
        x_left:   BOX_XSZ'(bus.job_x_left),
        x_right:  BOX_XSZ'(bus.job_x_right),
        y_top:    BOX_YSZ'(bus.job_y_top),
        y_bottom: BOX_YSZ'(bus.job_y_bottom)
    };

    assign bus.job_ready = !full;
    assign accept        = bus.job_valid && !full;

`ifdef BOX_ORDER_CHECK_EN
    logic bad_box_q;

    // The handshake still completes for a misordered box; it is simply never queued.
    assign fifo_push = accept && !box_misordered(job_in);

    always_ff @(posedge clk) begin
        if (!resetn) bad_box_q <= 1'b0;
        else         bad_box_q <= accept && box_misordered(job_in);
    end

    assign bus.bad_box = bad_box_q;
`else
    assign fifo_push   = accept;
    assign bus.bad_box = 1'b0;
`endif

    box_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (job_in),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        go_clean_c = 1'b0;
        busy_c     = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (!empty && bus.done_clean) begin
                    state_nxt = ST_LAUNCH;
                    fifo_pop  = 1'b1;
                end
            end
            ST_LAUNCH: begin
                go_clean_c = 1'b1;
                state_nxt  = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // A done level still high here is stale from before the launch.
                if (!bus.done_clean) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.done_clean) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_c    = 1'b0;
            end
        endcase
    end

    // The engine re-reads these every row, so they only change on a launch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_left_q   <= '0;
            x_right_q  <= '0;
            y_top_q    <= '0;
            y_bottom_q <= '0;
        end else if (fifo_pop) begin
            x_left_q   <= XSZ'(head.x_left);
            x_right_q  <= XSZ'(head.x_right);
            y_top_q    <= YSZ'(head.y_top);
            y_bottom_q <= YSZ'(head.y_bottom);
        end
    end

    assign bus.x_left   = x_left_q;
    assign bus.x_right  = x_right_q;
    assign bus.y_top    = y_top_q;
    assign bus.y_bottom = y_bottom_q;
    assign bus.go_clean = go_clean_c;
    assign bus.busy     = busy_c;
    assign bus.pending  = count;

endmodule

// File: tb/tb_box_clean_scheduler.sv
// Directed bench for box_clean_scheduler with a launch scoreboard and a behavioural clean engine.
module tb_box_clean_scheduler;
    localparam int XSZ   = 8;
    localparam int YSZ   = 7;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    box_clean_scheduler_if #(.XSZ(XSZ), .YSZ(YSZ), .DEPTH(DEPTH)) bus ();

    box_clean_scheduler #(.XSZ(XSZ), .YSZ(YSZ), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [29:0] exp_q [$];
    logic [29:0] mon_exp;
    logic [29:0] last_box = '0;
    logic [29:0] out_box;
    int          launch_count = 0;
    logic        prev_busy = 1'b0;

    assign out_box = {bus.x_left, bus.x_right, bus.y_top, bus.y_bottom};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every go_clean pops the oldest expected box.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.go_clean === 1'b1) begin
                chk("idle_gap", 32'(prev_busy), 32'd0);
                chk("busy_in_launch", 32'(bus.busy), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_go", 32'(bus.go_clean), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("launch_box", 32'(out_box), 32'(mon_exp));
                    last_box = mon_exp;
                    launch_count++;
                end
            end else if (bus.busy === 1'b1) begin
                chk("box_stable", 32'(out_box), 32'(last_box));
            end
            prev_busy = bus.busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    // Clean engine: drops done drop_after cycles after go, raises it busy_len cycles later.
    int drop_after = 1;
    int busy_len   = 30;
    bit eng_hold   = 1'b0;
    int eph        = 0;
    int ecnt       = 0;

    always @(negedge clk) begin
        if (resetn !== 1'b1) begin
            eph            = 0;
            bus.done_clean = 1'b1;
        end else begin
            case (eph)
                0: if (bus.go_clean === 1'b1) begin
                    ecnt = drop_after;
                    if (ecnt == 0) begin
                        bus.done_clean = 1'b0;
                        ecnt           = busy_len;
                        eph            = 2;
                    end else begin
                        eph = 1;
                    end
                end
                1: begin
                    ecnt--;
                    if (ecnt == 0) begin
                        bus.done_clean = 1'b0;
                        ecnt           = busy_len;
                        eph            = 2;
                    end
                end
                default: if (!eng_hold) begin
                    if (ecnt <= 1) begin
                        bus.done_clean = 1'b1;
                        eph            = 0;
                    end else begin
                        ecnt--;
                    end
                end
            endcase
        end
    end

    task automatic push_job(input logic [7:0] xl, input logic [7:0] xr,
                            input logic [6:0] yt, input logic [6:0] yb, input bit queued);
        int n = 0;
        bus.job_valid    = 1'b1;
        bus.job_x_left   = xl;
        bus.job_x_right  = xr;
        bus.job_y_top    = yt;
        bus.job_y_bottom = yb;
        while (bus.job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("push_timeout", 32'(bus.job_ready), 32'd1);
            bus.job_valid = 1'b0;
        end else begin
            if (queued) exp_q.push_back({xl, xr, yt, yb});
            @(posedge clk);
            @(negedge clk);
            bus.job_valid = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_go(input int budget);
        int n = 0;
        while (bus.go_clean !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("go_timeout", 32'(bus.go_clean), 32'd1);
    endtask

    task automatic count_busy(output int nb);
        nb = 0;
        while (bus.busy === 1'b1 && nb < 300) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy !== 1'b0 || bus.pending !== '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_launches(input int target, input int budget);
        int n = 0;
        while (launch_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("launch_timeout", 32'(launch_count), 32'(target));
    endtask

    int nb;
    int snap;

    initial begin
        resetn           = 1'b0;
        bus.job_valid    = 1'b0;
        bus.job_x_left   = '0;
        bus.job_x_right  = '0;
        bus.job_y_top    = '0;
        bus.job_y_bottom = '0;
        wait_cycles(3);
        chk("rst_go", 32'(bus.go_clean), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bad_box", 32'(bus.bad_box), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_box", 32'(out_box), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.job_ready), 32'd1);

        // Single job, engine drops one cycle after go and is busy for 30 cycles.
        drop_after = 1;
        busy_len   = 30;
        push_job(8'd10, 8'd20, 7'd5, 7'd8, 1'b1);
        chk("single_pending", 32'(bus.pending), 32'd1);
        chk("single_go_early", 32'(bus.go_clean), 32'd0);
        @(negedge clk);
        chk("single_latency_go", 32'(bus.go_clean), 32'd1);
        count_busy(nb);
        chk("single_busy_cycles", 32'(nb), 32'd32);
        chk("single_launches", 32'(launch_count), 32'd1);

        // Fill the FIFO behind a stalled engine, then drain in order.
        eng_hold = 1'b1;
        busy_len = 5;
        push_job(8'd1, 8'd11, 7'd1, 7'd2, 1'b1);
        push_job(8'd2, 8'd12, 7'd3, 7'd4, 1'b1);
        push_job(8'd3, 8'd13, 7'd5, 7'd6, 1'b1);
        push_job(8'd4, 8'd14, 7'd7, 7'd8, 1'b1);
        push_job(8'd5, 8'd15, 7'd9, 7'd10, 1'b1);
        chk("full_pending", 32'(bus.pending), 32'd4);
        bus.job_valid    = 1'b1;
        bus.job_x_left   = 8'd99;
        bus.job_x_right  = 8'd100;
        bus.job_y_top    = 7'd1;
        bus.job_y_bottom = 7'd1;
        for (int i = 0; i < 3; i++) begin
            chk("full_ready", 32'(bus.job_ready), 32'd0);
            chk("full_hold_pending", 32'(bus.pending), 32'd4);
            @(negedge clk);
        end
        bus.job_valid = 1'b0;
        eng_hold      = 1'b0;
        wait_launches(6, 400);
        wait_idle(100);
        chk("fill_drained", 32'(exp_q.size()), 32'd0);

        // Done stays high three cycles after go: must not count as completion.
        drop_after = 3;
        busy_len   = 4;
        push_job(8'd1, 8'd2, 7'd3, 7'd4, 1'b1);
        wait_go(10);
        count_busy(nb);
        chk("wait_low_busy_cycles", 32'(nb), 32'd8);

        // Reset while in WAIT_DONE with two jobs queued.
        drop_after = 1;
        busy_len   = 30;
        eng_hold   = 1'b1;
        push_job(8'd40, 8'd50, 7'd10, 7'd20, 1'b1);
        push_job(8'd41, 8'd51, 7'd11, 7'd21, 1'b1);
        push_job(8'd42, 8'd52, 7'd12, 7'd22, 1'b1);
        wait_cycles(3);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        chk("mid_pending", 32'(bus.pending), 32'd2);
        chk("mid_done_low", 32'(bus.done_clean), 32'd0);
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        resetn   = 1'b1;
        eng_hold = 1'b0;
        chk("mid_rst_pending", 32'(bus.pending), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_box", 32'(out_box), 32'd0);
        chk("mid_rst_ready", 32'(bus.job_ready), 32'd1);
        snap = launch_count;
        wait_cycles(40);
        chk("mid_rst_no_go", 32'(launch_count), 32'(snap));

        // Misordered box.
        busy_len = 5;
        snap     = launch_count;
`ifdef BOX_ORDER_CHECK_EN
        push_job(8'd20, 8'd10, 7'd5, 7'd8, 1'b0);
        chk("bad_box_pulse", 32'(bus.bad_box), 32'd1);
        chk("bad_box_pending", 32'(bus.pending), 32'd0);
        @(negedge clk);
        chk("bad_box_one_cycle", 32'(bus.bad_box), 32'd0);
        wait_cycles(10);
        chk("bad_box_no_go", 32'(launch_count), 32'(snap));
`else
        push_job(8'd20, 8'd10, 7'd5, 7'd8, 1'b1);
        chk("order_bad_box_tied", 32'(bus.bad_box), 32'd0);
        wait_go(10);
        wait_idle(100);
        chk("order_launched", 32'(launch_count), 32'(snap + 1));
`endif

        // Push and pop on the same edge with two queued.
        snap     = launch_count;
        eng_hold = 1'b1;
        push_job(8'd30, 8'd40, 7'd1, 7'd2, 1'b1);
        push_job(8'd31, 8'd41, 7'd3, 7'd4, 1'b1);
        push_job(8'd32, 8'd42, 7'd5, 7'd6, 1'b1);
        chk("pp_pending_pre", 32'(bus.pending), 32'd2);
        eng_hold = 1'b0;
        nb = 0;
        while (bus.busy !== 1'b0 && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        chk("pp_idle_reached", 32'(bus.busy), 32'd0);
        push_job(8'd33, 8'd43, 7'd7, 7'd8, 1'b1);
        chk("pp_pending_same", 32'(bus.pending), 32'd2);
        chk("pp_go_after_pop", 32'(bus.go_clean), 32'd1);
        wait_launches(snap + 4, 400);
        wait_idle(100);
        chk("pp_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/box_clean_scheduler.md
BOX_CLEAN_SCHEDULER -- requirements
Module: box_clean_scheduler

Interface
REQ-001 Parameters SHALL be: XSZ, default 8, x coordinate width; YSZ, default 7, y coordinate width; DEPTH, default 4, job FIFO entries (power of two, >=2).
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 job_valid  in  1  requester presents a box-clean job.
REQ-005 job_ready  out  1  scheduler can accept a job this cycle.
REQ-006 job_x_left, job_x_right  in  XSZ each  job box horizontal bounds, inclusive.
REQ-007 job_y_top, job_y_bottom  in  YSZ each  job box vertical bounds, inclusive.
REQ-008 x_left, x_right  out  XSZ each  box bounds driven to clean engine.
REQ-009 y_top, y_bottom  out  YSZ each  box bounds driven to clean engine.
REQ-010 go_clean  out  1  one-cycle start pulse to clean engine.
REQ-011 done_clean  in  1  clean engine idle/finished level.
REQ-012 busy  out  1  a job is launched and not yet completed.
REQ-013 pending  out  $clog2(DEPTH+1)  jobs queued, excluding the in-flight job.
REQ-014 bad_box  out  1  one-cycle pulse when a job is dropped (configuration-dependent).

Function
REQ-015 Job SHALL be accepted on a cycle with job_valid && job_ready; job_ready SHALL equal (pending != DEPTH), combinational from occupancy only (no dependence on job_valid).
REQ-016 Accepted jobs SHALL queue FIFO-order; full FIFO with valid high SHALL hold off without loss or overwrite.
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_LOW, WAIT_DONE.
REQ-018 IDLE->LAUNCH when pending!=0 and done_clean==1; on that edge head entry SHALL be popped into x_left/x_right/y_top/y_bottom.
REQ-019 LAUNCH SHALL assert go_clean for exactly one cycle, then go to WAIT_LOW.
REQ-020 WAIT_LOW SHALL ignore done_clean==1 and go to WAIT_DONE on first cycle done_clean==0 (engine has left its done state).
REQ-021 WAIT_DONE SHALL return to IDLE on first cycle done_clean==1.
REQ-022 Box outputs SHALL stay constant from LAUNCH until the next IDLE->LAUNCH edge (engine reloads x_left every row).
REQ-023 busy SHALL be 1 in LAUNCH, WAIT_LOW, WAIT_DONE; 0 in IDLE.
REQ-024 Latency: job accepted at edge N into empty FIFO with state IDLE and done_clean=1 SHALL produce go_clean high in cycle after edge N+1.
REQ-025 Push and pop on same edge SHALL leave pending unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 Back-to-back jobs SHALL be separated by at least one IDLE cycle.

Reset
REQ-027 resetn low at an edge SHALL force: state IDLE, FIFO empty, pending 0, job_ready 1 after release, go_clean 0, busy 0, bad_box 0, all box outputs 0.
REQ-028 Reset mid-job SHALL discard queued and in-flight jobs; no go_clean until a new job is accepted.

Configuration
REQ-029 Macro BOX_ORDER_CHECK_EN defined: a job with job_x_left>job_x_right or job_y_top>job_y_bottom SHALL be accepted (handshake completes) but not queued, with bad_box pulsed the following cycle.
REQ-030 Macro BOX_ORDER_CHECK_EN undefined: all accepted jobs SHALL be queued unchanged; bad_box SHALL be tied 0.

Structure
REQ-031 Shared package SHALL hold the state encoding enum and the box job struct type (x_left, x_right, y_top, y_bottom).
REQ-032 FIFO SHALL be a separate sub-module box_job_fifo (push, pop, full, empty, count); FSM and output registers stay in box_clean_scheduler.

Verification
REQ-033 Single job (10,20,5,8), done_clean model drops 1 cycle after go_clean and rises 30 cycles later -> one go_clean pulse, outputs 10/20/5/8 stable, busy high until done rises.
REQ-034 Push 5 jobs with DEPTH=4, engine stalled -> first popped into flight, 4 queued, job_ready 0 on sixth attempt, all 5 launched in order.
REQ-035 done_clean held high 3 cycles after go_clean -> no completion; state stays WAIT_LOW until done low, then waits for rise.
REQ-036 Reset asserted in WAIT_DONE with 2 jobs queued -> pending 0, busy 0, go_clean never pulses afterward without new job.
REQ-037 BOX_ORDER_CHECK_EN defined, job (20,10,5,8) -> bad_box pulse, pending 0, no go_clean; undefined -> job launched unchanged.
REQ-038 Simultaneous push and pop with pending=2 -> pending remains 2, order preserved.
